// File: rtl/iobus_int_ctrl_if.sv
// IOBUS memory-mapped access bundle between the MCU (master) and a peripheral (slave).
interface iobus_int_ctrl_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
    modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/iobus_int_ctrl.sv
// Interrupt controller: edge-latched PENDING, MASK gating, fixed-width INT pulse, ack + holdoff.
// Optional macro INTC_CAUSE_EN maps a priority-encoded CAUSE register at BASE_AD+0xC.
module iobus_int_ctrl #(
    parameter int          N_SRC       = 8,
    parameter logic [31:0] BASE_AD     = 32'h11040000,
    parameter int          INT_WIDTH   = 4,
    parameter int          HOLDOFF_CYC = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [N_SRC-1:0]   IRQ_SRC,
    iobus_int_ctrl_if.slave    bus,
    output logic               INT
);
    localparam int CNT_MAX = (INT_WIDTH > HOLDOFF_CYC) ? INT_WIDTH : HOLDOFF_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(INT_WIDTH - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [N_SRC-1:0] pend_q, pend_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [N_SRC-1:0] prev_q;
    logic             gen_q, gen_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_SRC-1:0] edge_det, clr_bits, active;
    logic             sel_pend, sel_mask, sel_ctrl;
    logic             wr_pend;
    logic [31:0]      rd_data;
    logic             unused_wdata;

    assign sel_pend = (bus.IOBUS_ADDR == BASE_AD);
    assign sel_mask = (bus.IOBUS_ADDR == BASE_AD + 32'h4);
    assign sel_ctrl = (bus.IOBUS_ADDR == BASE_AD + 32'h8);
    assign wr_pend  = bus.IOBUS_WR && sel_pend;

    assign edge_det = IRQ_SRC & ~prev_q;
    assign clr_bits = wr_pend ? bus.IOBUS_OUT[N_SRC-1:0] : '0;
    // New edges override a simultaneous W1C so no request is lost.
    assign pend_d   = (pend_q & ~clr_bits) | edge_det;
    assign mask_d   = (bus.IOBUS_WR && sel_mask) ? bus.IOBUS_OUT[N_SRC-1:0] : mask_q;
    assign gen_d    = (bus.IOBUS_WR && sel_ctrl) ? bus.IOBUS_OUT[0] : gen_q;
    assign active   = pend_q & mask_q;
    assign unused_wdata = ^bus.IOBUS_OUT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!gen_q) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (|active) begin
                    state_d = S_PULSE;
                    cnt_d   = PULSE_LD;
                end
                S_PULSE: if (cnt_q == '0) state_d = S_WAIT;
                         else             cnt_d   = cnt_q - 1'b1;
                // Any write to PENDING acknowledges, whatever the data.
                S_WAIT: if (wr_pend) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end
                S_HOLD: if (cnt_q == '0) state_d = S_IDLE;
                        else             cnt_d   = cnt_q - 1'b1;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_q  <= '0;
            mask_q  <= '0;
            gen_q   <= 1'b0;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            prev_q  <= IRQ_SRC;
        end else begin
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            gen_q   <= gen_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= IRQ_SRC;
        end
    end

    assign INT = (state_q == S_PULSE);

`ifdef INTC_CAUSE_EN
    logic       sel_cause;
    logic [4:0] cause_idx;

    assign sel_cause = (bus.IOBUS_ADDR == BASE_AD + 32'hC);

    // Scan downward so the lowest-numbered active source wins.
    always_comb begin
        cause_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) cause_idx = 5'(i);
        end
    end
`endif

    always_comb begin
        rd_data = '0;
        if (sel_pend)      rd_data[N_SRC-1:0] = pend_q;
        else if (sel_mask) rd_data[N_SRC-1:0] = mask_q;
        else if (sel_ctrl) rd_data[2:0]       = {state_q, gen_q};
`ifdef INTC_CAUSE_EN
        else if (sel_cause) rd_data = {|active, 26'b0, cause_idx};
`endif
    end

    assign bus.IOBUS_IN = rd_data;
endmodule

// File: tb/tb_iobus_int_ctrl.sv
// Directed bench for iobus_int_ctrl; expectations adapt to INTC_CAUSE_EN.
module tb_iobus_int_ctrl;
    localparam logic [31:0] BASE = 32'h11040000;
    localparam logic [31:0] A_PEND  = BASE;
    localparam logic [31:0] A_MASK  = BASE + 32'h4;
    localparam logic [31:0] A_CTRL  = BASE + 32'h8;
    localparam logic [31:0] A_CAUSE = BASE + 32'hC;
    localparam logic [31:0] A_NONE  = BASE + 32'h10;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] IRQ_SRC;
    logic       INT;
    int         total = 0;
    int         bad = 0;

    iobus_int_ctrl_if bus();

    iobus_int_ctrl #(
        .N_SRC(8), .BASE_AD(BASE), .INT_WIDTH(4), .HOLDOFF_CYC(8)
    ) dut (
        .CLK(CLK), .RST(RST), .IRQ_SRC(IRQ_SRC), .bus(bus), .INT(INT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data);
        bus.IOBUS_ADDR = addr;
        bus.IOBUS_OUT  = data;
        bus.IOBUS_WR   = 1'b1;
        tick();
        bus.IOBUS_WR   = 1'b0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_ADDR = '0;
    endtask

    task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
        bus.IOBUS_ADDR = addr;
        #1;
        data = bus.IOBUS_IN;
        bus.IOBUS_ADDR = '0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int int_seen;
        IRQ_SRC = 8'h01;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_pend: got %h want %h", rd, 32'h0); end
        bus_rd(A_MASK, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_mask: got %h want %h", rd, 32'h0); end
        bus_rd(A_CTRL, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_ctrl: got %h want %h", rd, 32'h0); end
        int_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (INT !== 1'b0) int_seen++;
        end
        total++; if (int_seen != 0) begin bad++; $display("FAIL reset_int_quiet: got %0d high cycles want 0", int_seen); end
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_held_src: got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_pulse();
        logic [31:0] rd;
        IRQ_SRC = 8'h00;
        tick();
        bus_wr(A_MASK, 32'h1);
        bus_wr(A_CTRL, 32'h1);
        IRQ_SRC = 8'h01;
        tick();
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL pulse_pend: got %h want %h", rd, 32'h1); end
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL pulse_int_t: got %b want 0", INT); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            total++; if (INT !== 1'b1) begin bad++; $display("FAIL pulse_int_t+%0d: got %b want 1", i, INT); end
        end
        tick();
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL pulse_int_end: got %b want 0", INT); end
        bus_rd(A_CTRL, rd);
        total++; if (rd !== 32'h5) begin bad++; $display("FAIL pulse_state_wait: got %h want %h", rd, 32'h5); end
    endtask

    task automatic test_holdoff();
        logic [31:0] rd;
        int int_seen;
        bus_wr(A_PEND, 32'h1);
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL ack_clear: got %h want %h", rd, 32'h0); end
        bus_rd(A_CTRL, rd);
        total++; if (rd !== 32'h7) begin bad++; $display("FAIL ack_state_hold: got %h want %h", rd, 32'h7); end
        IRQ_SRC = 8'h00;
        tick();
        IRQ_SRC = 8'h01;
        tick();
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL hold_latch: got %h want %h", rd, 32'h1); end
        int_seen = (INT !== 1'b0) ? 1 : 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (INT !== 1'b0) int_seen++;
        end
        total++; if (int_seen != 0) begin bad++; $display("FAIL hold_int_quiet: got %0d high cycles want 0", int_seen); end
        tick();
        total++; if (INT !== 1'b1) begin bad++; $display("FAIL hold_refire: got %b want 1", INT); end
        repeat (3) tick();
        tick();
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL hold_refire_end: got %b want 0", INT); end
        bus_wr(A_PEND, 32'h1);
        repeat (8) tick();
    endtask

    task automatic test_mask();
        logic [31:0] rd;
        int int_seen;
        IRQ_SRC = 8'h05;
        tick();
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL mask_pend: got %h want %h", rd, 32'h4); end
        int_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (INT !== 1'b0) int_seen++;
        end
        total++; if (int_seen != 0) begin bad++; $display("FAIL mask_block: got %0d high cycles want 0", int_seen); end
        bus_wr(A_MASK, 32'h5);
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL mask_wr_cycle: got %b want 0", INT); end
        tick();
        total++; if (INT !== 1'b1) begin bad++; $display("FAIL mask_unblock: got %b want 1", INT); end
        repeat (4) tick();
        bus_wr(A_PEND, 32'h4);
        repeat (8) tick();
        bus_rd(A_CTRL, rd);
        total++; if (rd !== 32'h1) begin bad++; $display("FAIL mask_back_idle: got %h want %h", rd, 32'h1); end
    endtask

    task automatic test_w1c_collision();
        logic [31:0] rd;
        bus.IOBUS_ADDR = A_PEND;
        bus.IOBUS_OUT  = 32'h8;
        bus.IOBUS_WR   = 1'b1;
        IRQ_SRC        = 8'h0D;
        tick();
        bus.IOBUS_WR   = 1'b0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_ADDR = '0;
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h8) begin bad++; $display("FAIL w1c_set_wins: got %h want %h", rd, 32'h8); end
        bus_wr(A_PEND, 32'h8);
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h want %h", rd, 32'h0); end
    endtask

    task automatic test_gen_off();
        logic [31:0] rd;
        IRQ_SRC = 8'h09;
        tick();
        IRQ_SRC = 8'h0D;
        tick();
        tick();
        total++; if (INT !== 1'b1) begin bad++; $display("FAIL gen_pulse_start: got %b want 1", INT); end
        bus_wr(A_CTRL, 32'h0);
        tick();
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL gen_off_int: got %b want 0", INT); end
        bus_rd(A_CTRL, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL gen_off_ctrl: got %h want %h", rd, 32'h0); end
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h4) begin bad++; $display("FAIL gen_off_pend_kept: got %h want %h", rd, 32'h4); end
        bus_wr(A_PEND, 32'h4);
    endtask

    task automatic test_cause();
        logic [31:0] rd;
        logic [31:0] exp_cause;
        bus_wr(A_MASK, 32'hFF);
        IRQ_SRC = 8'h09;
        tick();
        IRQ_SRC = 8'h0F;
        tick();
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h6) begin bad++; $display("FAIL cause_pend: got %h want %h", rd, 32'h6); end
`ifdef INTC_CAUSE_EN
        exp_cause = 32'h80000001;
`else
        exp_cause = 32'h00000000;
`endif
        bus_rd(A_CAUSE, rd);
        total++; if (rd !== exp_cause) begin bad++; $display("FAIL cause_read: got %h want %h", rd, exp_cause); end
        bus_wr(A_CAUSE, 32'hFFFFFFFF);
        bus_wr(A_NONE, 32'hFFFFFFFF);
        bus_rd(A_PEND, rd);
        total++; if (rd !== 32'h6) begin bad++; $display("FAIL unmapped_wr_pend: got %h want %h", rd, 32'h6); end
        bus_rd(A_MASK, rd);
        total++; if (rd !== 32'hFF) begin bad++; $display("FAIL unmapped_wr_mask: got %h want %h", rd, 32'hFF); end
        bus_rd(A_NONE, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL unmapped_read: got %h want %h", rd, 32'h0); end
        total++; if (INT !== 1'b0) begin bad++; $display("FAIL cause_gen_off_int: got %b want 0", INT); end
    endtask

    initial begin
        RST            = 1'b1;
        IRQ_SRC        = '0;
        bus.IOBUS_ADDR = '0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_WR   = 1'b0;
        test_reset();
        test_pulse();
        test_holdoff();
        test_mask();
        test_w1c_collision();
        test_gen_off();
        test_cause();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
